// File: rtl/seq_pkg.sv
// Shared constants for the note sequencer: pattern entry layout and FSM state encodings.
package seq_pkg;

   localparam int unsigned ENTRY_W   = 5;
   localparam int unsigned REST_BIT  = 4;
   localparam int unsigned PITCH_MSB = 3;

   // Every pattern slot comes out of reset as a rest with pitch 0.
   localparam logic [ENTRY_W-1:0] ENTRY_RESET = 5'h10;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StNote = 2'd1;
   localparam logic [1:0] StGap  = 2'd2;

endpackage

// File: rtl/tick_prescaler.sv
// Tempo prescaler: counts 0..TICK_DIV-1 and flags a tick on the last count.
module tick_prescaler #(
   parameter int unsigned TICK_DIV = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   output logic tick_o
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == CntW'(TICK_DIV - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/note_sequencer.sv
// Steps through a programmable pattern of pitch codes at a fixed tempo, driving pitch and a
// gate to the waveform generator. Pattern memory, tick counter and FSM live here.
module note_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned STEPS     = 8,
   parameter int unsigned TICK_DIV  = 1000,
   parameter int unsigned GAP_TICKS = 1,
   localparam int unsigned AW       = $clog2(STEPS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en_i,
   input  logic [AW-1:0]      wr_addr_i,
   input  logic [ENTRY_W-1:0] wr_data_i,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic               loop_i,
   input  logic [3:0]         tempo_i,
   output logic [3:0]         pitch_o,
   output logic               gate_o,
   output logic [AW-1:0]      step_idx_o,
   output logic               busy_o,
   output logic               done_o
);

   localparam int unsigned TcW = ($clog2(GAP_TICKS) > 4) ? $clog2(GAP_TICKS) : 4;

   logic [ENTRY_W-1:0] mem_q [STEPS];
   logic [ENTRY_W-1:0] mem_d [STEPS];
   logic [1:0]         state_q, state_d;
   logic [AW-1:0]      step_q, step_d;
   logic [3:0]         pitch_q, pitch_d;
   logic [3:0]         tempo_q, tempo_d;
   logic               gate_q, gate_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [TcW-1:0]     tcnt_q, tcnt_d;
   logic               tick;
   logic               clear;
   logic               enter_note;
   logic [AW-1:0]      enter_idx;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .clear_i (clear),
      .tick_o  (tick)
   );

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      pitch_d    = pitch_q;
      tempo_d    = tempo_q;
      gate_d     = gate_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      clear      = 1'b0;
      enter_note = 1'b0;
      enter_idx  = step_q;

      if (stop_i) begin
         state_d = StIdle;
         gate_d  = 1'b0;
         busy_d  = 1'b0;
         clear   = 1'b1;
      end else if (start_i) begin
         enter_note = 1'b1;
         enter_idx  = '0;
      end else begin
         case (state_q)
            StNote: begin
               if (tick && (tcnt_q == TcW'(tempo_q))) begin
                  state_d = StGap;
                  gate_d  = 1'b0;
                  clear   = 1'b1;
               end
            end
            StGap: begin
               if (tick && (tcnt_q == TcW'(GAP_TICKS - 1))) begin
                  if (step_q != AW'(STEPS - 1)) begin
                     enter_note = 1'b1;
                     enter_idx  = step_q + 1'b1;
                  end else if (loop_i) begin
                     enter_note = 1'b1;
                     enter_idx  = '0;
                  end else begin
                     state_d = StIdle;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     clear   = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end

      // Reads mem_q, so a write landing on this same edge is only heard on the next visit.
      if (enter_note) begin
         state_d = StNote;
         step_d  = enter_idx;
         pitch_d = mem_q[enter_idx][PITCH_MSB:0];
         gate_d  = ~mem_q[enter_idx][REST_BIT];
         tempo_d = tempo_i;
         busy_d  = 1'b1;
         clear   = 1'b1;
      end

      if (clear) begin
         tcnt_d = '0;
      end else if (tick) begin
         tcnt_d = tcnt_q + 1'b1;
      end else begin
         tcnt_d = tcnt_q;
      end

      mem_d = mem_q;
      if (wr_en_i) begin
         mem_d[wr_addr_i] = wr_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         step_q  <= '0;
         pitch_q <= '0;
         tempo_q <= '0;
         gate_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tcnt_q  <= '0;
         for (int i = 0; i < int'(STEPS); i++) begin
            mem_q[i] <= ENTRY_RESET;
         end
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         pitch_q <= pitch_d;
         tempo_q <= tempo_d;
         gate_q  <= gate_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         tcnt_q  <= tcnt_d;
         mem_q   <= mem_d;
      end
   end

   assign pitch_o    = pitch_q;
   assign gate_o     = gate_q;
   assign step_idx_o = step_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: expected output segments (tuple + run length) are queued
// by the stimulus and checked by an independent monitor whenever the output tuple changes.
module tb_note_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = '0;
   logic [4:0] wr_data = '0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       loop = 1'b0;
   logic [3:0] tempo = 4'd1;
   logic [3:0] pitch;
   logic       gate;
   logic [2:0] step_idx;
   logic       busy;
   logic       done;

   always #5 clk = ~clk;

   note_sequencer #(
      .STEPS     (8),
      .TICK_DIV  (4),
      .GAP_TICKS (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .start_i    (start),
      .stop_i     (stop),
      .loop_i     (loop),
      .tempo_i    (tempo),
      .pitch_o    (pitch),
      .gate_o     (gate),
      .step_idx_o (step_idx),
      .busy_o     (busy),
      .done_o     (done)
   );

   // Segment: output tuple {done,busy,gate,pitch,step_idx} and how many cycles it lasts (-1 = any).
   typedef struct {
      logic [9:0] tup;
      int         len;
   } seg_t;

   seg_t       exp_q[$];
   int         n_checks = 0;
   int         n_fail = 0;
   bit         mon_en = 1'b0;
   bit         started = 1'b0;
   logic [9:0] cur_tup;
   int         cur_len;

   function automatic logic [9:0] obs();
      return {done, busy, gate, pitch, step_idx};
   endfunction

   function automatic logic [9:0] mk(input logic d, input logic b, input logic g,
                                     input logic [3:0] p, input logic [2:0] s);
      return {d, b, g, p, s};
   endfunction

   task automatic push(input logic [9:0] t, input int l);
      seg_t s;
      s.tup = t;
      s.len = l;
      exp_q.push_back(s);
   endtask

   // A rest merges NOTE and GAP into one segment since gate is 0 throughout.
   task automatic push_step(input logic [3:0] p, input logic [2:0] s, input logic rest,
                            input int tmp);
      if (rest) begin
         push(mk(1'b0, 1'b1, 1'b0, p, s), (tmp + 2) * 4);
      end else begin
         push(mk(1'b0, 1'b1, 1'b1, p, s), (tmp + 1) * 4);
         push(mk(1'b0, 1'b1, 1'b0, p, s), 4);
      end
   endtask

   task automatic push_done(input logic [3:0] p);
      push(mk(1'b1, 1'b0, 1'b0, p, 3'd7), 1);
      push(mk(1'b0, 1'b0, 1'b0, p, 3'd7), -1);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [2:0] a, input logic [4:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      cycles(1);
      wr_en   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycles(1);
      start = 1'b0;
   endtask

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic wait_idle(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (!busy) break;
         cycles(1);
      end
      n_checks++;
      if (busy) begin
         n_fail++;
         $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, max_cycles);
      end
   endtask

   initial begin : monitor
      logic [9:0] t;
      seg_t       e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            t = obs();
            if (!started) begin
               started = 1'b1;
               cur_tup = t;
               cur_len = 1;
            end else if (t === cur_tup) begin
               cur_len++;
            end else begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL segment: got tup=%h len=%0d, required no further change",
                           cur_tup, cur_len);
               end else begin
                  e = exp_q.pop_front();
                  if (e.tup !== cur_tup || (e.len >= 0 && e.len != cur_len)) begin
                     n_fail++;
                     $display("FAIL segment: got tup=%h len=%0d, required tup=%h len=%0d",
                              cur_tup, cur_len, e.tup, e.len);
                  end
               end
               cur_tup = t;
               cur_len = 1;
            end
         end
      end
   end

   initial begin : stimulus
      logic [3:0] p4 [8];
      logic       r4 [8];

      cycles(3);
      check("reset_state", obs(), 10'h000);
      push(mk(1'b0, 1'b0, 1'b0, 4'h0, 3'd0), -1);
      mon_en = 1'b1;
      reset  = 1'b0;
      cycles(2);

      // 1: empty pattern, all rests, 12 cycles per step.
      tempo = 4'd1;
      loop  = 1'b0;
      for (int k = 0; k < 8; k++) push_step(4'h0, 3'(k), 1'b1, 1);
      push_done(4'h0);
      pulse_start();
      check("t1_busy_latency", {9'd0, busy}, 10'd1);
      check("t1_gate_rest", {9'd0, gate}, 10'd0);
      wait_idle(2000);
      cycles(3);

      // 2: pitches 1..8, single pass.
      for (int k = 0; k < 8; k++) write(3'(k), {1'b0, 4'(k + 1)});
      for (int k = 0; k < 8; k++) push_step(4'(k + 1), 3'(k), 1'b0, 1);
      push_done(4'h8);
      pulse_start();
      wait_idle(2000);
      cycles(3);

      // 3: looping, loop dropped during step 3 of the second pass.
      loop = 1'b1;
      for (int pass = 0; pass < 2; pass++)
         for (int k = 0; k < 8; k++) push_step(4'(k + 1), 3'(k), 1'b0, 1);
      push_done(4'h8);
      pulse_start();
      cycles(134);
      loop = 1'b0;
      wait_idle(2000);
      cycles(3);

      // 4: writes during playback, incl. one landing on the edge step 4 is entered.
      loop = 1'b1;
      p4 = '{4'h1, 4'h2, 4'h3, 4'h9, 4'h5, 4'h6, 4'h7, 4'h8};
      for (int k = 0; k < 8; k++) push_step(p4[k], 3'(k), 1'b0, 1);
      p4 = '{4'h1, 4'h2, 4'hF, 4'h9, 4'hA, 4'h6, 4'h7, 4'h8};
      r4 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 8; k++) push_step(p4[k], 3'(k), r4[k], 1);
      push_done(4'h8);
      pulse_start();
      cycles(25);
      write(3'd2, 5'h1F);
      write(3'd3, 5'h09);
      cycles(20);
      write(3'd4, 5'h0A);
      cycles(86);
      loop = 1'b0;
      wait_idle(2000);
      cycles(3);

      // 5: stop mid-NOTE of step 4, then stop+start together.
      for (int k = 0; k < 4; k++) push_step(p4[k], 3'(k), r4[k], 1);
      push(mk(1'b0, 1'b1, 1'b1, 4'hA, 3'd4), 2);
      push(mk(1'b0, 1'b0, 1'b0, 4'hA, 3'd4), -1);
      pulse_start();
      cycles(49);
      stop = 1'b1;
      cycles(1);
      stop = 1'b0;
      check("t5_stop", obs(), mk(1'b0, 1'b0, 1'b0, 4'hA, 3'd4));
      stop  = 1'b1;
      start = 1'b1;
      cycles(1);
      stop  = 1'b0;
      start = 1'b0;
      check("t5_stop_start", obs(), mk(1'b0, 1'b0, 1'b0, 4'hA, 3'd4));
      cycles(15);
      check("t5_stays_idle", obs(), mk(1'b0, 1'b0, 1'b0, 4'hA, 3'd4));

      // 6: reset during step 5 of a looping run; memory returns to rests.
      loop = 1'b1;
      for (int k = 0; k < 5; k++) push_step(p4[k], 3'(k), r4[k], 1);
      push(mk(1'b0, 1'b1, 1'b1, 4'h6, 3'd5), 2);
      push(mk(1'b0, 1'b0, 1'b0, 4'h0, 3'd0), -1);
      pulse_start();
      cycles(61);
      reset = 1'b1;
      cycles(1);
      check("t6_reset", obs(), 10'h000);
      reset = 1'b0;
      loop  = 1'b0;
      cycles(2);
      for (int k = 0; k < 8; k++) push_step(4'h0, 3'(k), 1'b0 | 1'b1, 1);
      push_done(4'h0);
      pulse_start();
      check("t6_gate_rest", {9'd0, gate}, 10'd0);
      wait_idle(2000);
      cycles(3);

      // 7: tempo 0 gives 1-tick notes.
      write(3'd0, 5'h03);
      tempo = 4'd0;
      push_step(4'h3, 3'd0, 1'b0, 0);
      for (int k = 1; k < 8; k++) push_step(4'h0, 3'(k), 1'b1, 0);
      push_done(4'h0);
      pulse_start();
      wait_idle(2000);
      cycles(3);

      // 8: tempo 15 gives 16-tick notes; tempo change mid-step applies from the next step.
      tempo = 4'd15;
      push_step(4'h3, 3'd0, 1'b0, 15);
      for (int k = 1; k < 8; k++) push_step(4'h0, 3'(k), 1'b1, 0);
      push_done(4'h0);
      pulse_start();
      cycles(9);
      tempo = 4'd0;
      wait_idle(2000);
      cycles(3);

      // 9: start while busy restarts at step 0 without a done pulse.
      push_step(4'h3, 3'd0, 1'b0, 0);
      push(mk(1'b0, 1'b1, 1'b0, 4'h0, 3'd1), 2);
      push_step(4'h3, 3'd0, 1'b0, 0);
      for (int k = 1; k < 8; k++) push_step(4'h0, 3'(k), 1'b1, 0);
      push_done(4'h0);
      pulse_start();
      cycles(9);
      pulse_start();
      wait_idle(2000);
      cycles(3);

      n_checks++;
      if (exp_q.size() != 1 || exp_q[0].tup !== cur_tup) begin
         n_fail++;
         $display("FAIL final_queue: got %0d pending segments (current tup=%h), required 1",
                  exp_q.size(), cur_tup);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
